// File: rtl/riscv_alu.sv
// 32-bit RISC-V integer ALU with NZCV flags, a combinational result path and
// an enable-gated registered copy for the following pipeline stage.
module riscv_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  input  logic        en,
  output logic [31:0] res,
  output logic [3:0]  flags,
  output logic [31:0] res_q,
  output logic [3:0]  flags_q
);

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W:0]   sum_p0;
  logic        [DATA_W:0]   diff_p0;
  logic                     big_sh;
  logic        [4:0]        sh;
  logic        [DATA_W-1:0] res_c;
  logic                     c_c;
  logic                     v_c;

  assign a_s = $signed(a);
  assign b_s = $signed(b);

  // The whole 32-bit b is the shift amount; anything >= 32 shifts everything out.
  assign big_sh = |b[31:5];
  assign sh     = b[4:0];

  // Subtraction as a + ~b + 1 so the carry out reads as "no borrow".
  assign sum_p0  = {1'b0, a} + {1'b0, b};
  assign diff_p0 = {1'b0, a} + {1'b0, ~b} + 33'd1;

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = sum_p0[DATA_W-1:0];
        c_c   = sum_p0[DATA_W];
        v_c   = (a[31] == b[31]) && (sum_p0[31] != a[31]);
      end
      OP_SUB: begin
        res_c = diff_p0[DATA_W-1:0];
        c_c   = diff_p0[DATA_W];
        v_c   = (a[31] != b[31]) && (diff_p0[31] != a[31]);
      end
      OP_AND:  res_c = a & b;
      OP_OR:   res_c = a | b;
      OP_XOR:  res_c = a ^ b;
      OP_SLL:  res_c = big_sh ? '0 : (a << sh);
      OP_SRL:  res_c = big_sh ? '0 : (a >> sh);
      OP_SRA:  res_c = big_sh ? {DATA_W{a[31]}} : $unsigned(a_s >>> sh);
      OP_SLT:  res_c = {31'd0, (a_s < b_s)};
      OP_SLTU: res_c = {31'd0, (a < b)};
      default: res_c = '0;
    endcase
  end

  assign res   = res_c;
  assign flags = {res_c[31], (res_c == '0), c_c, v_c};

  // Registered copy for the next stage and flag-based branch logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      flags_q <= 4'b0000;
    end else if (en) begin
      res_q   <= res;
      flags_q <= flags;
    end
  end

endmodule

// File: tb/tb_riscv_alu.sv
// Bench for riscv_alu: directed vector table, randomized vectors against a
// behavioural model, and register/reset sequences, all through a scoreboard queue.
module tb_riscv_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        en;
  logic [31:0] res;
  logic [3:0]  flags;
  logic [31:0] res_q;
  logic [3:0]  flags_q;

  riscv_alu dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .op      (op),
    .en      (en),
    .res     (res),
    .flags   (flags),
    .res_q   (res_q),
    .flags_q (flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic add_vec(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] r, input logic [3:0] f);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.res = r; v.flags = f;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input logic [31:0] r, input logic [3:0] f, input int id);
    exp_t e;
    e.res = r; e.flags = f; e.id = id;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s #%0d: got %h, expected %h", name, id, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare it with either the live or registered outputs.
  task automatic check_out(input string name, input bit registered);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, got %h expected none", name, res);
      return;
    end
    e = sb.pop_front();
    if (registered) begin
      cmp({name, "_res_q"}, e.id, res_q, e.res);
      cmp({name, "_flags_q"}, e.id, {28'd0, flags_q}, {28'd0, e.flags});
    end else begin
      cmp({name, "_res"}, e.id, res, e.res);
      cmp({name, "_flags"}, e.id, {28'd0, flags}, {28'd0, e.flags});
    end
  endtask

  // Behavioural reference: wide signed arithmetic and bit-by-bit shifting.
  function automatic void model(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                                output logic [31:0] r, output logic [3:0] f);
    longint      sa, sbv, wide;
    logic [63:0] uw;
    logic        c, v;
    int unsigned cnt;
    sa  = longint'($signed(va));
    sbv = longint'($signed(vb));
    c = 1'b0; v = 1'b0; r = '0;
    cnt = (vb > 32'd40) ? 40 : int'(vb);
    case (o)
      4'd0: begin
        wide = sa + sbv;
        uw = {32'd0, va} + {32'd0, vb};
        r = uw[31:0]; c = uw[32];
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd1: begin
        wide = sa - sbv;
        r = va - vb; c = (va >= vb);
        v = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd2: r = va & vb;
      4'd3: r = va | vb;
      4'd4: r = va ^ vb;
      4'd5: begin r = va; for (int i = 0; i < int'(cnt); i++) r = {r[30:0], 1'b0}; end
      4'd6: begin r = va; for (int i = 0; i < int'(cnt); i++) r = {1'b0, r[31:1]}; end
      4'd7: begin r = va; for (int i = 0; i < int'(cnt); i++) r = {r[31], r[31:1]}; end
      4'd8: r = (sa < sbv) ? 32'd1 : 32'd0;
      4'd9: r = ({32'd0, va} < {32'd0, vb}) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    f = {r[31], (r == 32'd0), c, v};
  endfunction

  initial begin
    logic [31:0] mr;
    logic [3:0]  mf;

    add_vec(4'd2, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'b0100);
    add_vec(4'd2, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 4'b0000);
    add_vec(4'd3, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 4'b1000);
    add_vec(4'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
    add_vec(4'd4, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 4'b1000);
    add_vec(4'd4, 32'h0000003F, 32'h0000002A, 32'h00000015, 4'b0000);
    add_vec(4'd5, 32'h0000000F, 32'd4,        32'h000000F0, 4'b0000);
    add_vec(4'd5, 32'h0000000F, 32'd31,       32'h80000000, 4'b1000);
    add_vec(4'd5, 32'h0000000F, 32'd32,       32'h00000000, 4'b0100);
    add_vec(4'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);
    add_vec(4'd6, 32'h0000000F, 32'd3,        32'h00000001, 4'b0000);
    add_vec(4'd6, 32'h00000001, 32'd1,        32'h00000000, 4'b0100);
    add_vec(4'd7, 32'h80000000, 32'h00000040, 32'hFFFFFFFF, 4'b1000);
    add_vec(4'd7, 32'h80000000, 32'd4,        32'hF8000000, 4'b1000);
    add_vec(4'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001);
    add_vec(4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110);
    add_vec(4'd1, 32'h00000005, 32'h00000005, 32'h00000000, 4'b0110);
    add_vec(4'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000);
    add_vec(4'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011);
    add_vec(4'd8, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 4'b0000);
    add_vec(4'd9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0100);
    add_vec(4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100);
    add_vec(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100);

    // Reset asserted with no clock edge yet seen.
    rst_n = 1'b0; en = 1'b0; op = 4'd0; a = '0; b = '0;
    #1;
    cmp("reset_res_q", 0, res_q, 32'h0);
    cmp("reset_flags_q", 0, {28'd0, flags_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      op = tbl[i].op; a = tbl[i].a; b = tbl[i].b;
      push_exp(tbl[i].res, tbl[i].flags, i);
      #1;
      check_out("vec", 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom();
      b = (i % 3 == 0) ? $urandom() : 32'($urandom_range(0, 40));
      model(op, a, b, mr, mf);
      push_exp(mr, mf, 100 + i);
      #1;
      check_out("rand", 1'b0);
    end

    // Capture with en=1.
    @(negedge clk);
    op = 4'd2; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; en = 1'b1;
    push_exp(32'hFFFFFFFF, 4'b1000, 200);
    @(posedge clk); #1;
    check_out("capture", 1'b1);

    // Hold with en=0 while inputs change; live outputs follow the new inputs.
    @(negedge clk);
    en = 1'b0; op = 4'd0; a = 32'd1; b = 32'd2;
    push_exp(32'd3, 4'b0000, 201);
    #1;
    check_out("hold_live", 1'b0);
    push_exp(32'hFFFFFFFF, 4'b1000, 202);
    repeat (2) @(posedge clk);
    #1;
    check_out("hold", 1'b1);

    // Asynchronous reset between edges; live path keeps tracking inputs.
    @(negedge clk);
    en = 1'b1; op = 4'd1; a = 32'd0; b = 32'd1;
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(32'h0, 4'b0000, 203);
    check_out("async_rst", 1'b1);
    push_exp(32'hFFFFFFFF, 4'b1000, 204);
    check_out("rst_live", 1'b0);
    @(posedge clk); #1;
    push_exp(32'h0, 4'b0000, 205);
    check_out("rst_held", 1'b1);

    // First enabled edge after release captures.
    @(negedge clk);
    rst_n = 1'b1;
    op = 4'd0; a = 32'h7FFFFFFF; b = 32'd1;
    push_exp(32'h80000000, 4'b1001, 206);
    @(posedge clk); #1;
    check_out("post_rst", 1'b1);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
